// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32I data memory: funct3 size codes, FSM
// states, byte-enable generation, store-lane replication and load extension.
package dmem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } dmem_state_t;

  // f3[1:0] carries the access size for every legal code (00 B, 01 H, 10 W).
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      MEM_B:   load_extend = {{24{b[7]}}, b};
      MEM_BU:  load_extend = {24'h0, b};
      MEM_H:   load_extend = {{16{h[15]}}, h};
      MEM_HU:  load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory; master = EX/MEM side, slave = memory.
interface data_memory_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // A beat transfers on a rising edge where valid && ready; the sender holds
  // its payload stable while valid is high and ready is low.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 storage: byte-enable synchronous write, registered read on re.
module dmem_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    // Read only on load accept so the held response word cannot change.
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: decode, error check, 1-deep response FSM, lane steering.
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_unit_if.slave   bus,
  output dmem_state_t         state_dbg
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;

  dmem_state_t state;
  logic        rsp_err, rsp_load;
  logic [2:0]  rsp_f3;
  logic [1:0]  rsp_off;
  logic [31:0] bank_rdata;

  logic [2:0]        f3;
  logic [ADDR_W-1:0] addr;
  logic              is_half, is_word, legal_f3;
  logic              range_err, f3_err, align_err, req_err;
  logic [1:0]        off;
  logic              req_ready, accept;

  assign f3       = bus.req_funct3;
  assign addr     = bus.req_addr;
  assign is_half  = (f3[1:0] == 2'b01);
  assign is_word  = (f3[1:0] == 2'b10);
  assign legal_f3 = (f3 == MEM_B) || (f3 == MEM_H) || (f3 == MEM_W) ||
                    (f3 == MEM_BU) || (f3 == MEM_HU);

  assign range_err = ({1'b0, addr} >= LIMIT);
  assign f3_err    = !legal_f3 || (bus.req_we && f3[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_err = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign off       = addr[1:0];
`else
  assign align_err = 1'b0;
  assign off       = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif

  assign req_err   = range_err || f3_err || align_err;
  assign req_ready = !rst && ((state == IDLE) || bus.resp_ready);
  assign accept    = bus.req_valid && req_ready;

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .we    (accept && bus.req_we && !req_err),
    .re    (accept && !bus.req_we && !req_err),
    .be    (byte_en(f3, off)),
    .addr  (addr[AW+1:2]),
    .wdata (store_data(f3, bus.req_wdata)),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rsp_err  <= 1'b0;
      rsp_load <= 1'b0;
      rsp_f3   <= 3'b000;
      rsp_off  <= 2'b00;
    end else if (accept) begin
      state    <= RESP;
      rsp_err  <= req_err;
      rsp_load <= !bus.req_we && !req_err;
      rsp_f3   <= f3;
      rsp_off  <= off;
    end else if (state == RESP && bus.resp_ready) begin
      state <= IDLE;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && rsp_err;
  assign bus.resp_rdata = ((state == RESP) && rsp_load) ?
                          load_extend(bank_rdata, rsp_f3, rsp_off) : 32'h0;
  assign state_dbg      = state;
endmodule
